// File: rtl/frame_pointer_stack.sv
// Frame pointer register with a DEPTH-entry save stack for ENTER/LEAVE call sequences.
// Writes take effect on the next rising edge; ebp, flags and conflict are registered outputs.
module frame_pointer_stack #(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0999,
  parameter logic [3:0]  WR_CODE_A   = 4'h2,
  parameter logic [3:0]  WR_CODE_B   = 4'h5,
  localparam int         CW          = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             phase_a,
  input  logic             phase_b,
  input  logic [3:0]       read_or_write,
  input  logic [WIDTH-1:0] write_data,
  input  logic             enter,
  input  logic             leave,
  input  logic [WIDTH-1:0] esp_in,
  input  logic             err_clear,
  output logic [WIDTH-1:0] ebp,
  output logic [WIDTH-1:0] saved_top,
  output logic [CW-1:0]    depth_count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic             conflict
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] ebp_q, ebp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             conf_q, conf_d;

  logic [AW-1:0] push_idx, pop_idx;
  logic          wr_hit, do_push, do_pop, is_full, is_empty;

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);
  assign push_idx = AW'(cnt_q);
  assign pop_idx  = AW'(cnt_q - CW'(1));

  // Only one code is present per cycle, so at most one slot can match.
  assign wr_hit  = (phase_a && read_or_write == WR_CODE_A) ||
                   (phase_b && read_or_write == WR_CODE_B);
  assign do_push = enter && !leave && !is_full;
  assign do_pop  = leave && !enter && !is_empty;

  always_comb begin
    ebp_d = ebp_q;
    cnt_d = cnt_q;
    if (do_push) begin
      ebp_d = esp_in;
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      ebp_d = stack_q[pop_idx];
      cnt_d = cnt_q - CW'(1);
    end else if (wr_hit && !enter && !leave) begin
      ebp_d = write_data;
    end
    // A newly detected error beats a same-cycle clear.
    ovf_d  = (enter && !leave && is_full)  || (ovf_q && !err_clear);
    unf_d  = (leave && !enter && is_empty) || (unf_q && !err_clear);
    conf_d = (enter && leave) || (wr_hit && (enter || leave));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ebp_q  <= RESET_VALUE[WIDTH-1:0];
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      if (do_push) stack_q[push_idx] <= ebp_q;
      ebp_q  <= ebp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      conf_q <= conf_d;
    end
  end

  assign ebp         = ebp_q;
  assign saved_top   = is_empty ? '0 : stack_q[pop_idx];
  assign depth_count = cnt_q;
  assign full        = is_full;
  assign empty       = is_empty;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign conflict    = conf_q;

endmodule

// File: tb/tb_frame_pointer_stack.sv
// Bench for frame_pointer_stack: directed steps plus random traffic against a queue-based model.
module tb_frame_pointer_stack;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset, phase_a, phase_b, enter, leave, err_clear;
  logic [3:0]  read_or_write;
  logic [31:0] write_data, esp_in;
  logic [31:0] ebp, saved_top;
  logic [3:0]  depth_count;
  logic        full, empty, overflow, underflow, conflict;

  int checks = 0;
  int errors = 0;

  frame_pointer_stack dut (
    .clock(clock), .reset(reset), .phase_a(phase_a), .phase_b(phase_b),
    .read_or_write(read_or_write), .write_data(write_data), .enter(enter),
    .leave(leave), .esp_in(esp_in), .err_clear(err_clear), .ebp(ebp),
    .saved_top(saved_top), .depth_count(depth_count), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow), .conflict(conflict)
  );

  always #5 clock = ~clock;

  // Reference model: ebp value, saved frames as a LIFO queue, flags.
  logic [31:0] m_ebp;
  logic [31:0] m_stk [$];
  logic        m_ovf, m_unf, m_conf;

  task automatic model_update(input logic rst, e, l, pa, pb, input logic [3:0] rw,
                              input logic [31:0] wd, esp, input logic clr);
    logic wr, set_o, set_u;
    if (!rst) begin
      m_ebp = 32'h999; m_stk.delete(); m_ovf = 0; m_unf = 0; m_conf = 0;
      return;
    end
    wr = (pa && rw == 4'h2) || (pb && rw == 4'h5);
    set_o = 0; set_u = 0;
    m_conf = (e && l) || (wr && (e || l));
    if (e && !l) begin
      if (m_stk.size() == DEPTH) set_o = 1;
      else begin m_stk.push_back(m_ebp); m_ebp = esp; end
    end else if (l && !e) begin
      if (m_stk.size() == 0) set_u = 1;
      else m_ebp = m_stk.pop_back();
    end else if (!e && !l && wr) begin
      m_ebp = wd;
    end
    m_ovf = set_o || (m_ovf && !clr);
    m_unf = set_u || (m_unf && !clr);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("ebp", ebp, m_ebp);
    check("saved_top", saved_top, (m_stk.size() == 0) ? 32'h0 : m_stk[$]);
    check("depth", 32'(depth_count), 32'(m_stk.size()));
    check("full", 32'(full), 32'(m_stk.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_stk.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("conflict", 32'(conflict), 32'(m_conf));
  endtask

  // Drive one cycle of inputs, clock it, then compare everything #1 after the edge.
  task automatic step(input logic rst, e, l, pa, pb, input logic [3:0] rw,
                      input logic [31:0] wd, esp, input logic clr);
    reset = rst; enter = e; leave = l; phase_a = pa; phase_b = pb;
    read_or_write = rw; write_data = wd; esp_in = esp; err_clear = clr;
    @(posedge clock);
    model_update(rst, e, l, pa, pb, rw, wd, esp, clr);
    #1;
    check_model();
  endtask

  task automatic idle();        step(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0); endtask
  task automatic do_enter(input logic [31:0] esp); step(1, 1, 0, 0, 0, 4'h0, 32'h0, esp, 0); endtask
  task automatic do_leave();    step(1, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0); endtask
  task automatic do_reset();    step(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0); endtask

  initial begin
    logic [31:0] keep;
    m_ebp = 32'h999; m_ovf = 0; m_unf = 0; m_conf = 0;

    // Reset, then idle
    do_reset();
    idle();
    check("rst_ebp", ebp, 32'h999);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_top", saved_top, 32'h0);

    // Direct writes
    step(1, 0, 0, 1, 0, 4'h2, 32'h1000, 32'h0, 0);
    check("wr_a", ebp, 32'h1000);
    step(1, 0, 0, 0, 1, 4'h5, 32'h2000, 32'h0, 0);
    check("wr_b", ebp, 32'h2000);
    step(1, 0, 0, 1, 0, 4'h5, 32'h3000, 32'h0, 0);
    check("wr_a_wrong_code", ebp, 32'h2000);
    step(1, 0, 0, 0, 1, 4'h2, 32'h3000, 32'h0, 0);
    check("wr_b_wrong_code", ebp, 32'h2000);

    // Nested frames
    step(1, 0, 0, 1, 0, 4'h2, 32'h100, 32'h0, 0);
    do_enter(32'h200); do_enter(32'h300); do_enter(32'h400);
    check("nest_ebp", ebp, 32'h400);
    check("nest_depth", 32'(depth_count), 32'd3);
    check("nest_top", saved_top, 32'h300);
    do_leave(); check("pop1", ebp, 32'h300);
    do_leave(); check("pop2", ebp, 32'h200);
    do_leave(); check("pop3", ebp, 32'h100);
    check("pop_empty", 32'(empty), 32'd1);

    // Boundaries
    for (int i = 0; i < DEPTH; i++) do_enter(32'h1000 + 32'(i) * 32'h10);
    check("full_set", 32'(full), 32'd1);
    do_enter(32'hBAD0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_ebp", ebp, 32'h1070);
    check("ovf_depth", 32'(depth_count), 32'd8);
    for (int i = 0; i < DEPTH; i++) do_leave();
    keep = ebp;
    do_leave();
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_ebp", ebp, keep);
    check("ovf_sticky", 32'(overflow), 32'd1);
    step(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    step(1, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    check("set_beats_clear", 32'(underflow), 32'd1);
    idle();
    check("conflict_one_cycle", 32'(conflict), 32'd0);

    // Simultaneous events
    do_enter(32'h700);
    keep = ebp;
    step(1, 1, 1, 0, 0, 4'h0, 32'h0, 32'h900, 0);
    check("el_conflict", 32'(conflict), 32'd1);
    check("el_ebp", ebp, keep);
    step(1, 1, 0, 1, 0, 4'h2, 32'hDEAD, 32'h5000, 0);
    check("enter_wr_ebp", ebp, 32'h5000);
    check("enter_wr_conflict", 32'(conflict), 32'd1);
    check("enter_wr_top", saved_top, 32'h700);
    idle();
    check("conflict_clears", 32'(conflict), 32'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) do_enter(32'h8000 + 32'(i));
    check("pre_rst_depth", 32'(depth_count), 32'd5);
    step(0, 1, 0, 0, 0, 4'h0, 32'h0, 32'hAAAA, 0);
    check("midrst_ebp", ebp, 32'h999);
    check("midrst_depth", 32'(depth_count), 32'd0);
    check("midrst_top", saved_top, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic        r, e, l, pa, pb, c;
      logic [3:0]  rw;
      logic [31:0] wd, esp;
      r   = ($urandom_range(0, 99) != 0);
      e   = ($urandom_range(0, 99) < 40);
      l   = ($urandom_range(0, 99) < 35);
      pa  = $urandom_range(0, 1) == 1;
      pb  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: rw = 4'h2;
        1: rw = 4'h5;
        default: rw = 4'($urandom_range(0, 15));
      endcase
      wd  = $urandom;
      esp = $urandom;
      c   = ($urandom_range(0, 9) == 0);
      step(r, e, l, pa, pb, rw, wd, esp, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
